// File: rtl/tempo_btn_controller.sv
// -----------------------------------------------------------------------------
// tempo_btn_controller
//   Turns the debounced UP/DN tempo buttons into BPM changes for the metronome
//   tick generator: a single press steps once, a hold auto-repeats (slow, then
//   fast), and both buttons together restore the default tempo.
//
// Optional feature macro: TEMPO_FAST_REPEAT_EN
//   defined   : after FAST_AFTER slow repeat steps the repeat speeds up to one
//               step every FAST_CYC cycles.
//   undefined : no FAST state and no repeat counter; SLOW repeats until release.
//
// Ports
//   i_clk          system clock
//   i_rst          synchronous reset, active high (wins over every input)
//   i_up_btn       debounced UP level, 1 = held
//   i_up_pressed   1-cycle pulse on the UP press edge
//   i_dn_btn       debounced DN level, 1 = held
//   i_dn_pressed   1-cycle pulse on the DN press edge
//   o_bpm          current tempo, registered
//   o_bpm_changed  1-cycle pulse in the cycle o_bpm shows a new value
//   o_repeat       1 while auto-repeating (SLOW/FAST), registered
// -----------------------------------------------------------------------------
module tempo_btn_controller #(
    parameter int BPM_W       = 9,
    parameter int BPM_MIN     = 30,
    parameter int BPM_MAX     = 300,
    parameter int BPM_DEFAULT = 120,
    parameter int HOLD_CYC    = 50_000_000,
    parameter int SLOW_CYC    = 12_500_000,
    parameter int FAST_CYC    = 2_500_000,
    parameter int FAST_AFTER  = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_up_btn,
    input  logic             i_up_pressed,
    input  logic             i_dn_btn,
    input  logic             i_dn_pressed,
    output logic [BPM_W-1:0] o_bpm,
    output logic             o_bpm_changed,
    output logic             o_repeat
);

    // The interval counter is sized for the longest interval it has to time;
    // FAST_CYC is included even when the fast stage is not built.
    localparam int CNT_MAX_HS = (HOLD_CYC > SLOW_CYC) ? HOLD_CYC : SLOW_CYC;
    localparam int CNT_MAX    = (CNT_MAX_HS > FAST_CYC) ? CNT_MAX_HS : FAST_CYC;
    localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_CYC - 1);

    localparam logic [BPM_W-1:0] BPM_ONE = BPM_W'(1);
    localparam logic [BPM_W-1:0] BPM_MIN_V = BPM_W'(BPM_MIN);
    localparam logic [BPM_W-1:0] BPM_MAX_V = BPM_W'(BPM_MAX);
    localparam logic [BPM_W-1:0] BPM_DEF_V = BPM_W'(BPM_DEFAULT);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_SLOW = 3'd2;
    localparam logic [2:0] ST_FAST = 3'd3;
    localparam logic [2:0] ST_BOTH = 3'd4;

`ifdef TEMPO_FAST_REPEAT_EN
    localparam int REP_W = (FAST_AFTER > 1) ? $clog2(FAST_AFTER + 1) : 1;
    localparam logic [REP_W-1:0] REP_ZERO  = REP_W'(0);
    localparam logic [REP_W-1:0] REP_ONE   = REP_W'(1);
    localparam logic [REP_W-1:0] REP_FINAL = REP_W'(FAST_AFTER);
    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_CYC - 1);

    logic [REP_W-1:0] rep_r;
    logic [REP_W-1:0] rep_nxt_s;
`endif

    logic [2:0]       state_r;
    logic [2:0]       state_nxt_s;
    logic             dir_up_r;
    logic             dir_up_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [BPM_W-1:0] bpm_r;
    logic [BPM_W-1:0] bpm_nxt_s;
    logic             bpm_changed_r;
    logic             repeat_r;

    logic             held_s;
    logic             opp_press_s;
    logic [BPM_W-1:0] bpm_step_s;

    // One BPM step in the given direction, clamped to the tempo range.
    function automatic logic [BPM_W-1:0] step_bpm(input logic [BPM_W-1:0] cur,
                                                  input logic             up);
        logic [BPM_W-1:0] res;
        if (up) begin
            if (cur >= BPM_MAX_V) res = BPM_MAX_V;
            else                  res = cur + BPM_ONE;
        end else begin
            if (cur <= BPM_MIN_V) res = BPM_MIN_V;
            else                  res = cur - BPM_ONE;
        end
        return res;
    endfunction

    // Level of the latched button, the opposite button's press pulse, and the
    // stepped tempo in the latched direction.
    always_comb begin
        held_s      = dir_up_r ? i_up_btn : i_dn_btn;
        opp_press_s = dir_up_r ? i_dn_pressed : i_up_pressed;
        bpm_step_s  = step_bpm(bpm_r, dir_up_r);
    end

    // Next-state logic. In the held states the opposite press beats release,
    // and release beats a step falling due in the same cycle.
    always_comb begin
        state_nxt_s  = state_r;
        dir_up_nxt_s = dir_up_r;
        cnt_nxt_s    = cnt_r;
        bpm_nxt_s    = bpm_r;
`ifdef TEMPO_FAST_REPEAT_EN
        rep_nxt_s    = rep_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if ((i_up_pressed && (i_dn_pressed || i_dn_btn)) ||
                    (i_dn_pressed && i_up_btn)) begin
                    state_nxt_s = ST_BOTH;
                    bpm_nxt_s   = BPM_DEF_V;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (i_up_pressed) begin
                    state_nxt_s  = ST_WAIT;
                    dir_up_nxt_s = 1'b1;
                    bpm_nxt_s    = step_bpm(bpm_r, 1'b1);
                    cnt_nxt_s    = CNT_ZERO;
                end else if (i_dn_pressed) begin
                    state_nxt_s  = ST_WAIT;
                    dir_up_nxt_s = 1'b0;
                    bpm_nxt_s    = step_bpm(bpm_r, 1'b0);
                    cnt_nxt_s    = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (opp_press_s) begin
                    state_nxt_s = ST_BOTH;
                    bpm_nxt_s   = BPM_DEF_V;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (!held_s) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == HOLD_LAST) begin
                    state_nxt_s = ST_SLOW;
                    bpm_nxt_s   = bpm_step_s;
                    cnt_nxt_s   = CNT_ZERO;
`ifdef TEMPO_FAST_REPEAT_EN
                    rep_nxt_s   = REP_ZERO;
`endif
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            ST_SLOW: begin
                if (opp_press_s) begin
                    state_nxt_s = ST_BOTH;
                    bpm_nxt_s   = BPM_DEF_V;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (!held_s) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == SLOW_LAST) begin
                    bpm_nxt_s = bpm_step_s;
                    cnt_nxt_s = CNT_ZERO;
`ifdef TEMPO_FAST_REPEAT_EN
                    // The step that brings rep up to FAST_AFTER promotes to FAST.
                    rep_nxt_s = rep_r + REP_ONE;
                    if ((rep_r + REP_ONE) >= REP_FINAL) begin
                        state_nxt_s = ST_FAST;
                        rep_nxt_s   = REP_FINAL;
                    end else begin
                        state_nxt_s = ST_SLOW;
                    end
`endif
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
`ifdef TEMPO_FAST_REPEAT_EN
            ST_FAST: begin
                if (opp_press_s) begin
                    state_nxt_s = ST_BOTH;
                    bpm_nxt_s   = BPM_DEF_V;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (!held_s) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == FAST_LAST) begin
                    bpm_nxt_s = bpm_step_s;
                    cnt_nxt_s = CNT_ZERO;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
`endif
            ST_BOTH: begin
                // Press pulses are ignored here; only a full release exits.
                if (!i_up_btn && !i_dn_btn) state_nxt_s = ST_IDLE;
                else                        state_nxt_s = ST_BOTH;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r       <= ST_IDLE;
            dir_up_r      <= 1'b0;
            cnt_r         <= CNT_ZERO;
            bpm_r         <= BPM_DEF_V;
            bpm_changed_r <= 1'b0;
            repeat_r      <= 1'b0;
`ifdef TEMPO_FAST_REPEAT_EN
            rep_r         <= REP_ZERO;
`endif
        end else begin
            state_r       <= state_nxt_s;
            dir_up_r      <= dir_up_nxt_s;
            cnt_r         <= cnt_nxt_s;
            bpm_r         <= bpm_nxt_s;
            bpm_changed_r <= (bpm_nxt_s != bpm_r);
            repeat_r      <= (state_nxt_s == ST_SLOW) || (state_nxt_s == ST_FAST);
`ifdef TEMPO_FAST_REPEAT_EN
            rep_r         <= rep_nxt_s;
`endif
        end
    end

    assign o_bpm         = bpm_r;
    assign o_bpm_changed = bpm_changed_r;
    assign o_repeat      = repeat_r;

endmodule

// File: tb/tb_tempo_btn_controller.sv
module tb_tempo_btn_controller;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_up_btn = 1'b0;
    logic       i_up_pressed = 1'b0;
    logic       i_dn_btn = 1'b0;
    logic       i_dn_pressed = 1'b0;
    logic [8:0] o_bpm;
    logic       o_bpm_changed;
    logic       o_repeat;

    int vec_count = 0;
    int err_count = 0;

    tempo_btn_controller #(
        .BPM_W(9), .BPM_MIN(30), .BPM_MAX(300), .BPM_DEFAULT(120),
        .HOLD_CYC(20), .SLOW_CYC(8), .FAST_CYC(2), .FAST_AFTER(3)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_up_btn(i_up_btn), .i_up_pressed(i_up_pressed),
        .i_dn_btn(i_dn_btn), .i_dn_pressed(i_dn_pressed),
        .o_bpm(o_bpm), .o_bpm_changed(o_bpm_changed), .o_repeat(o_repeat)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_up_btn = 1'b0; i_up_pressed = 1'b0;
        i_dn_btn = 1'b0; i_dn_pressed = 1'b0;
        tick(); tick();
        i_rst = 1'b0;
    endtask

    // Steps taken by tick k of a hold whose press pulse lands on tick 1.
    // First step at 1, hold step at 21, slow every 8; with the fast stage the
    // third slow step (tick 45) switches to a step every 2 ticks.
    function automatic int n_steps(input int k);
        if (k < 1) return 0;
        if (k < 21) return 1;
`ifdef TEMPO_FAST_REPEAT_EN
        if (k >= 45) return 5 + (k - 45) / 2;
`endif
        return 2 + (k - 21) / 8;
    endfunction

    task automatic test_reset();
        i_rst = 1'b1; i_up_btn = 1'b1; i_up_pressed = 1'b1;
        tick();
        vec_count++;
        if (o_bpm !== 9'd120 || o_bpm_changed !== 1'b0 || o_repeat !== 1'b0) begin
            err_count++;
            $display("FAIL reset: bpm=%0d chg=%0b rep=%0b expected 120/0/0", o_bpm, o_bpm_changed, o_repeat);
        end
        i_up_btn = 1'b0; i_up_pressed = 1'b0;
        tick();
        i_rst = 1'b0;
    endtask

    task automatic test_single_press();
        int pulses;
        int rep_seen;
        do_reset();
        pulses = 0; rep_seen = 0;
        i_up_btn = 1'b1; i_up_pressed = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k == 5) i_up_btn = 1'b0;
            tick();
            i_up_pressed = 1'b0;
            pulses += int'(o_bpm_changed);
            rep_seen += int'(o_repeat);
        end
        vec_count++;
        if (o_bpm !== 9'd121) begin
            err_count++;
            $display("FAIL single_bpm: got %0d expected 121", o_bpm);
        end
        vec_count++;
        if (pulses !== 1) begin
            err_count++;
            $display("FAIL single_pulses: got %0d expected 1", pulses);
        end
        vec_count++;
        if (rep_seen !== 0) begin
            err_count++;
            $display("FAIL single_repeat: repeat high %0d cycles expected 0", rep_seen);
        end
    endtask

    task automatic test_dn_hold();
        int exp_bpm;
        do_reset();
        i_dn_btn = 1'b1; i_dn_pressed = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            i_dn_pressed = 1'b0;
            exp_bpm = 120 - n_steps(k);
            vec_count++;
            if (o_bpm !== 9'(exp_bpm) || o_bpm_changed !== (n_steps(k) != n_steps(k - 1)) ||
                o_repeat !== (k >= 21)) begin
                err_count++;
                $display("FAIL dn_hold t=%0d: bpm=%0d chg=%0b rep=%0b expected %0d/%0b/%0b", k,
                         o_bpm, o_bpm_changed, o_repeat, exp_bpm,
                         n_steps(k) != n_steps(k - 1), k >= 21);
            end
        end
        // Release on a cycle where a step would otherwise be due: no step.
        i_dn_btn = 1'b0;
        tick();
        vec_count++;
        if (o_bpm !== 9'(120 - n_steps(60)) || o_bpm_changed !== 1'b0 || o_repeat !== 1'b0) begin
            err_count++;
            $display("FAIL dn_release: bpm=%0d chg=%0b rep=%0b expected %0d/0/0",
                     o_bpm, o_bpm_changed, o_repeat, 120 - n_steps(60));
        end
    endtask

    task automatic test_both_from_slow();
        int pulses;
        do_reset();
        i_dn_btn = 1'b1; i_dn_pressed = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            tick();
            i_dn_pressed = 1'b0;
        end
        vec_count++;
        if (o_bpm !== 9'd118 || o_repeat !== 1'b1) begin
            err_count++;
            $display("FAIL slow_entry: bpm=%0d rep=%0b expected 118/1", o_bpm, o_repeat);
        end
        i_up_btn = 1'b1; i_up_pressed = 1'b1;
        tick();
        i_up_pressed = 1'b0;
        vec_count++;
        if (o_bpm !== 9'd120 || o_bpm_changed !== 1'b1 || o_repeat !== 1'b0) begin
            err_count++;
            $display("FAIL both_entry: bpm=%0d chg=%0b rep=%0b expected 120/1/0", o_bpm, o_bpm_changed, o_repeat);
        end
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            if (k == 5)  i_dn_pressed = 1'b1;
            if (k == 20) i_up_btn = 1'b0;
            tick();
            i_dn_pressed = 1'b0;
            pulses += int'(o_bpm_changed) + int'(o_repeat) + int'(o_bpm != 9'd120);
        end
        vec_count++;
        if (pulses !== 0) begin
            err_count++;
            $display("FAIL both_hold: %0d activity cycles expected 0", pulses);
        end
        i_dn_btn = 1'b0;
        tick();
        i_up_btn = 1'b1; i_up_pressed = 1'b1;
        tick();
        i_up_pressed = 1'b0; i_up_btn = 1'b0;
        vec_count++;
        if (o_bpm !== 9'd121 || o_bpm_changed !== 1'b1) begin
            err_count++;
            $display("FAIL both_exit: bpm=%0d chg=%0b expected 121/1", o_bpm, o_bpm_changed);
        end
        tick();
    endtask

    task automatic test_idle_both();
        do_reset();
        i_up_btn = 1'b1; i_up_pressed = 1'b1;
        tick();
        i_up_pressed = 1'b0; i_up_btn = 1'b0;
        tick();
        i_up_btn = 1'b1; i_up_pressed = 1'b1; i_dn_btn = 1'b1; i_dn_pressed = 1'b1;
        tick();
        i_up_pressed = 1'b0; i_dn_pressed = 1'b0;
        vec_count++;
        if (o_bpm !== 9'd120 || o_bpm_changed !== 1'b1) begin
            err_count++;
            $display("FAIL idle_both_pulses: bpm=%0d chg=%0b expected 120/1", o_bpm, o_bpm_changed);
        end
        i_up_btn = 1'b0; i_dn_btn = 1'b0;
        tick();
        // DN level already held, UP press: both-buttons, already at default.
        i_dn_btn = 1'b1;
        tick();
        i_up_btn = 1'b1; i_up_pressed = 1'b1;
        tick();
        i_up_pressed = 1'b0;
        vec_count++;
        if (o_bpm !== 9'd120 || o_bpm_changed !== 1'b0) begin
            err_count++;
            $display("FAIL idle_both_level: bpm=%0d chg=%0b expected 120/0", o_bpm, o_bpm_changed);
        end
        i_up_btn = 1'b0; i_dn_btn = 1'b0;
        tick();
    endtask

    task automatic test_limits();
        int pulses;
        int rep_low;
        int over;
        do_reset();
        over = 0;
        i_up_btn = 1'b1; i_up_pressed = 1'b1;
        for (int k = 1; k <= 1500; k++) begin
            tick();
            i_up_pressed = 1'b0;
            if (o_bpm > 9'd300) over++;
        end
        vec_count++;
        if (o_bpm !== 9'd300 || over !== 0) begin
            err_count++;
            $display("FAIL max_reach: bpm=%0d over=%0d expected 300/0", o_bpm, over);
        end
        pulses = 0; rep_low = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            pulses += int'(o_bpm_changed);
            rep_low += int'(!o_repeat);
        end
        vec_count++;
        if (o_bpm !== 9'd300 || pulses !== 0 || rep_low !== 0) begin
            err_count++;
            $display("FAIL max_clamp: bpm=%0d pulses=%0d rep_low=%0d expected 300/0/0", o_bpm, pulses, rep_low);
        end
        i_up_btn = 1'b0;
        tick();
        i_dn_btn = 1'b1; i_dn_pressed = 1'b1;
        for (int k = 1; k <= 2300; k++) begin
            tick();
            i_dn_pressed = 1'b0;
            if (o_bpm < 9'd30) over++;
        end
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            pulses += int'(o_bpm_changed);
        end
        vec_count++;
        if (o_bpm !== 9'd30 || pulses !== 0 || over !== 0 || o_repeat !== 1'b1) begin
            err_count++;
            $display("FAIL min_clamp: bpm=%0d pulses=%0d under=%0d rep=%0b expected 30/0/0/1",
                     o_bpm, pulses, over, o_repeat);
        end
        i_up_btn = 1'b1; i_up_pressed = 1'b1;
        tick();
        i_up_pressed = 1'b0;
        vec_count++;
        if (o_bpm !== 9'd120 || o_bpm_changed !== 1'b1 || o_repeat !== 1'b0) begin
            err_count++;
            $display("FAIL min_both: bpm=%0d chg=%0b rep=%0b expected 120/1/0", o_bpm, o_bpm_changed, o_repeat);
        end
        i_up_btn = 1'b0; i_dn_btn = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_hold();
        int pulses;
        do_reset();
        i_up_btn = 1'b1; i_up_pressed = 1'b1;
        for (int k = 1; k <= 55; k++) begin
            tick();
            i_up_pressed = 1'b0;
        end
        vec_count++;
        if (o_bpm !== 9'(120 + n_steps(55)) || o_repeat !== 1'b1) begin
            err_count++;
            $display("FAIL up_hold55: bpm=%0d rep=%0b expected %0d/1", o_bpm, o_repeat, 120 + n_steps(55));
        end
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        vec_count++;
        if (o_bpm !== 9'd120 || o_repeat !== 1'b0 || o_bpm_changed !== 1'b0) begin
            err_count++;
            $display("FAIL mid_reset: bpm=%0d rep=%0b chg=%0b expected 120/0/0", o_bpm, o_repeat, o_bpm_changed);
        end
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            pulses += int'(o_bpm_changed) + int'(o_repeat) + int'(o_bpm != 9'd120);
        end
        vec_count++;
        if (pulses !== 0) begin
            err_count++;
            $display("FAIL post_reset_hold: %0d activity cycles expected 0", pulses);
        end
        i_up_btn = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_dn_hold();
        test_both_from_slow();
        test_idle_both();
        test_limits();
        test_reset_mid_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
